// File: rtl/list_sum_pkg.sv
// -----------------------------------------------------------------------------
// list_sum_pkg
// Shared definitions for the list-walking summation engine: FSM state type and
// default parameter values.
// Configuration macro: LIST_SUM_SATURATE_EN (consumed by list_sum_acc).
// -----------------------------------------------------------------------------
package list_sum_pkg;

    localparam int unsigned DefN        = 8;    // data word width
    localparam int unsigned DefAW       = 8;    // memory address width
    localparam int unsigned DefMaxNodes = 255;  // node-count guard

    typedef enum logic [2:0] {
        StIdle,
        StRdVal,
        StRdNxt,
        StLink,
        StFin
    } state_e;

endpackage : list_sum_pkg

// File: rtl/list_sum_acc.sv
// -----------------------------------------------------------------------------
// list_sum_acc
// N-bit unsigned accumulator with sticky carry-out flag.
// Configuration macro: LIST_SUM_SATURATE_EN
//   defined   : on carry out the sum clamps to all ones and stays clamped
//   undefined : the sum wraps modulo 2^N
// Ports:
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_clear        zero sum and overflow (start of a walk)
//   i_add          add i_addend this cycle
//   i_addend       value to accumulate
//   o_sum          accumulated value
//   o_overflow     sticky carry-out flag for the current walk
// -----------------------------------------------------------------------------
module list_sum_acc
    import list_sum_pkg::*;
#(
    parameter int unsigned N = DefN
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clear,
    input  logic         i_add,
    input  logic [N-1:0] i_addend,
    output logic [N-1:0] o_sum,
    output logic         o_overflow
);

    logic [N-1:0] r_sum;
    logic         r_overflow;
    logic [N:0]   w_ext;
    logic         w_carry;
    logic [N-1:0] w_sum_next;

    assign w_ext   = {1'b0, r_sum} + {1'b0, i_addend};
    assign w_carry = w_ext[N];

`ifdef LIST_SUM_SATURATE_EN
    // Once overflowed the sum stays pinned at all ones for the rest of the walk.
    assign w_sum_next = (w_carry || r_overflow) ? {N{1'b1}} : w_ext[N-1:0];
`else
    assign w_sum_next = w_ext[N-1:0];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sum      <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_sum      <= '0;
            r_overflow <= 1'b0;
        end else if (i_add) begin
            r_sum      <= w_sum_next;
            r_overflow <= r_overflow | w_carry;
        end
    end

    assign o_sum      = r_sum;
    assign o_overflow = r_overflow;

endmodule : list_sum_acc

// File: rtl/list_sum_engine.sv
// -----------------------------------------------------------------------------
// list_sum_engine
// Walks a linked list held in an external memory and sums the node values.
// Node layout: mem[p] = value, mem[p+1 (wrapping)] = next pointer (low AW bits).
// A next pointer of 0 ends the list; MAX_NODES bounds the walk so cyclic lists
// always terminate with o_err_limit set.
// Configuration macro: LIST_SUM_SATURATE_EN (see list_sum_acc).
// Parameters: N data width (must be >= AW), AW address width, MAX_NODES guard.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start, i_head   walk request and first-node address (sampled in idle)
//   o_busy            high whenever the FSM is not idle
//   o_done            one-cycle end-of-walk pulse (the cycle after FIN)
//   o_sum, o_count    result sum and number of visited nodes
//   o_overflow        sticky carry out of the sum during this walk
//   o_err_limit       walk stopped by the MAX_NODES guard
//   o_mem_rd, o_mem_addr, i_mem_rdata   memory read port, data one cycle later
// -----------------------------------------------------------------------------
module list_sum_engine
    import list_sum_pkg::*;
#(
    parameter int unsigned N         = DefN,
    parameter int unsigned AW        = DefAW,
    parameter int unsigned MAX_NODES = DefMaxNodes
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [AW-1:0] i_head,
    output logic          o_busy,
    output logic          o_done,
    output logic [N-1:0]  o_sum,
    output logic [AW-1:0] o_count,
    output logic          o_overflow,
    output logic          o_err_limit,
    output logic          o_mem_rd,
    output logic [AW-1:0] o_mem_addr,
    input  logic [N-1:0]  i_mem_rdata
);

    localparam logic [AW-1:0] MaxCnt = AW'(MAX_NODES);

    state_e        r_state;
    logic [AW-1:0] r_ptr;
    logic [AW-1:0] r_count;
    logic          r_err_limit;
    logic          r_done;
    logic          r_mem_rd;
    logic [AW-1:0] r_mem_addr;

    logic [AW-1:0] w_next_ptr;
    logic          w_accept;
    logic          w_add;

    assign w_next_ptr = i_mem_rdata[AW-1:0];
    assign w_accept   = (r_state == StIdle) && i_start;
    assign w_add      = (r_state == StRdNxt);

    // Read strobe and address are registered on the transition into the read
    // states, so they are valid throughout RD_VAL / RD_NXT.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_count     <= '0;
            r_err_limit <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_addr  <= '0;
        end else begin
            r_done   <= 1'b0;
            r_mem_rd <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_ptr       <= i_head;
                        r_count     <= '0;
                        r_err_limit <= 1'b0;
                        r_mem_rd    <= 1'b1;
                        r_mem_addr  <= i_head;
                        r_state     <= StRdVal;
                    end
                end
                StRdVal: begin
                    r_mem_rd   <= 1'b1;
                    r_mem_addr <= r_ptr + AW'(1);  // wraps at 2^AW
                    r_state    <= StRdNxt;
                end
                StRdNxt: begin
                    r_count <= r_count + AW'(1);
                    r_state <= StLink;
                end
                StLink: begin
                    if (w_next_ptr == '0) begin
                        r_state <= StFin;
                    end else if (r_count == MaxCnt) begin
                        r_err_limit <= 1'b1;
                        r_state     <= StFin;
                    end else begin
                        r_ptr      <= w_next_ptr;
                        r_mem_rd   <= 1'b1;
                        r_mem_addr <= w_next_ptr;
                        r_state    <= StRdVal;
                    end
                end
                StFin: begin
                    r_done  <= 1'b1;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    list_sum_acc #(
        .N (N)
    ) u_acc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_accept),
        .i_add      (w_add),
        .i_addend   (i_mem_rdata),
        .o_sum      (o_sum),
        .o_overflow (o_overflow)
    );

    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
    assign o_count     = r_count;
    assign o_err_limit = r_err_limit;
    assign o_mem_rd    = r_mem_rd;
    assign o_mem_addr  = r_mem_addr;

endmodule : list_sum_engine

// File: tb/tb_list_sum_engine.sv
// -----------------------------------------------------------------------------
// tb_list_sum_engine
// Directed bench for list_sum_engine with a behavioural one-cycle-latency
// memory. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_list_sum_engine;

    localparam int N  = 8;
    localparam int AW = 8;

`ifdef LIST_SUM_SATURATE_EN
    localparam int OvfSum = 255;
`else
    localparam int OvfSum = 44;   // (200 + 100) mod 256
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] head;
    logic          busy;
    logic          done;
    logic [N-1:0]  sum;
    logic [AW-1:0] count;
    logic          overflow;
    logic          err_limit;
    logic          mem_rd;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_rdata;

    logic [N-1:0]  mem [256];
    logic [AW-1:0] last_rd_addr;

    int n_checks = 0;
    int n_errors = 0;
    int lat;
    int dseen;

    always #5 clk = ~clk;

    list_sum_engine dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_head      (head),
        .o_busy      (busy),
        .o_done      (done),
        .o_sum       (sum),
        .o_count     (count),
        .o_overflow  (overflow),
        .o_err_limit (err_limit),
        .o_mem_rd    (mem_rd),
        .o_mem_addr  (mem_addr),
        .i_mem_rdata (mem_rdata)
    );

    // External memory: data valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) begin
            mem_rdata    <= mem[mem_addr];
            last_rd_addr <= mem_addr;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Launch a walk and wait for done; lat counts edges after the start edge.
    // pulse_at > 0 raises start (with a different head) during that cycle.
    task automatic do_walk(input logic [AW-1:0] h, input int budget, input int pulse_at,
                           output int lat_o);
        @(negedge clk);
        start = 1'b1;
        head  = h;
        @(posedge clk);
        #1;
        start = 1'b0;
        head  = '0;
        lat_o = 0;
        while (lat_o < budget) begin
            @(posedge clk);
            lat_o++;
            #1;
            if (lat_o == pulse_at) begin
                check_eq("busy_at_pulse", 32'(busy), 1);
                start = 1'b1;
                head  = 8'd20;
            end else begin
                start = 1'b0;
            end
            if (done) break;
        end
        start = 1'b0;
        check_eq("done_seen", 32'(done), 1);
    endtask

    task automatic check_done_drops();
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", 32'(done), 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem_rdata    = '0;
        last_rd_addr = '0;
        rst   = 1'b1;
        start = 1'b0;
        head  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_mem_rd", 32'(mem_rd), 0);
        check_eq("rst_sum", 32'(sum), 0);
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_flags", 32'({overflow, err_limit}), 0);
        check_eq("rst_mem_addr", 32'(mem_addr), 0);
        @(negedge clk);
        rst = 1'b0;

        // Two-node list 0 -> 4 -> end.
        mem[0] = 8'd5; mem[1] = 8'd4;
        mem[4] = 8'd7; mem[5] = 8'd0;
        do_walk(8'd0, 100, 0, lat);
        check_eq("l2_latency", lat, 7);
        check_eq("l2_busy_at_done", 32'(busy), 0);
        check_eq("l2_sum", 32'(sum), 12);
        check_eq("l2_count", 32'(count), 2);
        check_eq("l2_overflow", 32'(overflow), 0);
        check_eq("l2_err", 32'(err_limit), 0);
        check_eq("l2_last_addr", 32'(last_rd_addr), 5);
        check_done_drops();
        repeat (3) @(posedge clk);
        #1;
        check_eq("l2_sum_hold", 32'(sum), 12);
        check_eq("l2_count_hold", 32'(count), 2);

        // Overflow: 200 + 100.
        mem[20] = 8'd200; mem[21] = 8'd30;
        mem[30] = 8'd100; mem[31] = 8'd0;
        do_walk(8'd20, 100, 0, lat);
        check_eq("ov_sum", 32'(sum), OvfSum);
        check_eq("ov_flag", 32'(overflow), 1);
        check_eq("ov_count", 32'(count), 2);
        check_done_drops();

        // A fresh walk clears the sticky overflow.
        do_walk(8'd0, 100, 0, lat);
        check_eq("clr_overflow", 32'(overflow), 0);
        check_eq("clr_sum", 32'(sum), 12);

        // Self-loop stopped by the node guard.
        mem[9] = 8'd1; mem[10] = 8'd9;
        do_walk(8'd9, 1000, 0, lat);
        check_eq("loop_latency", lat, 766);
        check_eq("loop_err", 32'(err_limit), 1);
        check_eq("loop_count", 32'(count), 255);
        check_eq("loop_sum", 32'(sum), 255);
        check_eq("loop_overflow", 32'(overflow), 0);
        dseen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done) dseen++;
        end
        check_eq("loop_single_done", dseen, 0);

        // Node at the top address: next pointer fetched from address 0.
        mem[255] = 8'd17; mem[0] = 8'd0;
        do_walk(8'd255, 100, 0, lat);
        check_eq("wrap_latency", lat, 4);
        check_eq("wrap_count", 32'(count), 1);
        check_eq("wrap_sum", 32'(sum), 17);
        check_eq("wrap_last_addr", 32'(last_rd_addr), 0);
        check_eq("wrap_err", 32'(err_limit), 0);
        mem[0] = 8'd5;

        // start raised during RD_NXT is ignored.
        do_walk(8'd0, 100, 1, lat);
        check_eq("ign_latency", lat, 7);
        check_eq("ign_sum", 32'(sum), 12);
        check_eq("ign_count", 32'(count), 2);
        check_done_drops();

        // Reset asserted while in LINK aborts the walk.
        @(negedge clk);
        start = 1'b1;
        head  = 8'd0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("mid_busy", 32'(busy), 1);
        check_eq("mid_sum", 32'(sum), 5);
        rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 0);
        check_eq("arst_sum", 32'(sum), 0);
        check_eq("arst_count", 32'(count), 0);
        check_eq("arst_mem", 32'({mem_rd, mem_addr}), 0);
        @(posedge clk);
        #1;
        check_eq("arst_outs", 32'({busy, done, overflow, err_limit, mem_rd}), 0);
        @(negedge clk);
        rst = 1'b0;
        dseen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) dseen++;
        end
        check_eq("arst_no_done", dseen, 0);

        // First walk after reset behaves normally.
        do_walk(8'd0, 100, 0, lat);
        check_eq("post_latency", lat, 7);
        check_eq("post_sum", 32'(sum), 12);
        check_eq("post_count", 32'(count), 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_list_sum_engine
